div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter_pkg.sv | 21 ++
 rtl/div_step.sv | 27 ++
 rtl/div_iter.sv | 163 ++++++++++++++++
 tb/tb_div_iter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared core definitions: ALU operation codes plus the divider FSM encodings
// and the ready/not-ready constants.
package div_iter_pkg;

    typedef enum logic [7:0] {
        ALU_OP_NOP  = 8'h00,
        ALU_OP_DIV  = 8'h1A,
        ALU_OP_DIVU = 8'h1B
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           fits;

    // The partial remainder is always below the divisor, so the trial value is
    // below twice the divisor and diff's top bit acts as the borrow.
    always_comb begin
        trial = {rem_i, dvd_i[WIDTH-1]};
        diff  = trial - {1'b0, dvs_i};
        fits  = ~diff[WIDTH];
        rem_o = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_o = {dvd_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per clock. Result is
// {remainder, quotient}; signed mode divides magnitudes and corrects signs.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 neg_q_q, neg_q_d;
    logic                 neg_r_q, neg_r_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH-1:0]     step_rem, step_dvd;
    logic [WIDTH-1:0]     abs1, abs2;
    logic [WIDTH-1:0]     quot_fix, rem_fix;
    logic                 sign1, sign2;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .dvd_o (step_dvd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= DIV_NOT_READY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE: begin
                if (start_i && !annul_i)
                    state_d = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
            end
            DIV_BYZERO: state_d = annul_i ? DIV_FREE : DIV_END;
            DIV_ON: begin
                if (annul_i)
                    state_d = DIV_FREE;
                else if (cnt_q == CNT_LAST)
                    state_d = DIV_END;
            end
            DIV_END: begin
                if (!start_i || annul_i)
                    state_d = DIV_FREE;
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == DIV_ON) || (state_q == DIV_BYZERO);
    end

    // Magnitudes at latch time; the most-negative value maps onto itself,
    // which is still the correct unsigned magnitude.
    always_comb begin
        sign1    = signed_div_i & opdata1_i[WIDTH-1];
        sign2    = signed_div_i & opdata2_i[WIDTH-1];
        abs1     = sign1 ? -opdata1_i : opdata1_i;
        abs2     = sign2 ? -opdata2_i : opdata2_i;
        quot_fix = neg_q_q ? -dvd_q : dvd_q;
        rem_fix  = neg_r_q ? -rem_q : rem_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_NOT_READY;
                if (start_i && !annul_i) begin
                    dvd_d   = abs1;
                    dvs_d   = abs2;
                    rem_d   = '0;
                    cnt_d   = '0;
                    neg_q_d = sign1 ^ sign2;
                    neg_r_d = sign1;
                end
            end
            DIV_BYZERO: begin
                if (!annul_i) begin
                    result_d = '0;
                    ready_d  = DIV_READY;
                end
            end
            DIV_ON: begin
                if (!annul_i) begin
                    if (cnt_q != CNT_LAST) begin
                        dvd_d = step_dvd;
                        rem_d = step_rem;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        result_d = {rem_fix, quot_fix};
                        ready_d  = DIV_READY;
                    end
                end
            end
            DIV_END: begin
                if (!start_i || annul_i) begin
                    result_d = '0;
                    ready_d  = DIV_NOT_READY;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = DIV_NOT_READY;
            end
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter (WIDTH=32): vector table plus hand-written
// sequences for hold, annul, reset and ignored-input cases.
module tb_div_iter;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           signed_div_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           start_i;
    logic           annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           busy_o;

    int tests;
    int fails;

    typedef struct {
        logic           sgn;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_res;
        int             exp_lat;
    } vec_t;

    vec_t vecs[14];

    div_iter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts a divide and waits for ready_o; lat counts edges after E0,
    // busy_cnt counts sampled cycles with busy_o high. lat = -1 on timeout.
    task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [2*W-1:0] res, output int lat, output int busy_cnt);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat      = -1;
        busy_cnt = busy_o ? 1 : 0;
        res      = '0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = k;
                res = result_o;
                break;
            end
            if (busy_o) busy_cnt++;
        end
    endtask

    task automatic drop_start(input string name);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check({name, " ready after drop"}, {63'd0, ready_o}, 64'd0);
        check({name, " result after drop"}, result_o, 64'd0);
    endtask

    initial begin
        logic [2*W-1:0] res;
        int             lat;
        int             bc;
        logic           saw_ready;

        tests = 0;
        fails = 0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,        {32'h00000002, 32'h0000000E}, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,        {32'hFFFFFFFE, 32'hFFFFFFF2}, 33};
        vecs[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9, {32'h00000002, 32'hFFFFFFF2}, 33};
        vecs[3]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 33};
        vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 33};
        vecs[5]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h00000000}, 33};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'h00000000, 32'hFFFFFFFF}, 33};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, {32'h00000000, 32'h00000001}, 33};
        vecs[8]  = '{1'b0, 32'h12345678,   32'd0,        64'd0,                        1};
        vecs[9]  = '{1'b0, 32'h12345678,   32'h00000100, {32'h00000078, 32'h00123456}, 33};
        vecs[10] = '{1'b0, 32'd5,          32'd9,        {32'h00000005, 32'h00000000}, 33};
        vecs[11] = '{1'b1, 32'd7,          32'hFFFFFFFF, {32'h00000000, 32'hFFFFFFF9}, 33};
        vecs[12] = '{1'b1, 32'd0,          32'd5,        64'd0,                        33};
        vecs[13] = '{1'b1, 32'hFFFFFF9C,   32'd0,        64'd0,                        1};

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", {63'd0, ready_o}, 64'd0);
        check("reset result", result_o, 64'd0);
        check("reset busy", {63'd0, busy_o}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat, bc);
            check($sformatf("vec%0d result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d busy cycles", i), 64'(bc), 64'(vecs[i].exp_lat));
            drop_start($sformatf("vec%0d", i));
        end

        // Hold start past ready: result must stay put.
        run_div(1'b0, 32'd100, 32'd7, res, lat, bc);
        check("hold first result", res, {32'd2, 32'd14});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold ready %0d", i), {63'd0, ready_o}, 64'd1);
            check($sformatf("hold result %0d", i), result_o, {32'd2, 32'd14});
        end
        drop_start("hold");

        // Annul partway through 100/7; nothing may be reported for it.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        check("annul busy", {63'd0, busy_o}, 64'd0);
        check("annul ready", {63'd0, ready_o}, 64'd0);
        annul_i   = 1'b0;
        start_i   = 1'b0;
        saw_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) saw_ready = 1'b1;
        end
        check("annul no ready", {63'd0, saw_ready}, 64'd0);
        run_div(1'b0, 32'd9, 32'd3, res, lat, bc);
        check("after annul 9/3", res, {32'd0, 32'd3});
        drop_start("after annul");

        // Annul while in BYZERO.
        @(negedge clk);
        opdata1_i = 32'h12345678;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("byzero busy", {63'd0, busy_o}, 64'd1);
        annul_i = 1'b1;
        @(negedge clk);
        check("byzero annul busy", {63'd0, busy_o}, 64'd0);
        check("byzero annul ready", {63'd0, ready_o}, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;

        // Reset mid-divide, then a fresh 15/4.
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst mid ready", {63'd0, ready_o}, 64'd0);
        check("rst mid result", result_o, 64'd0);
        check("rst mid busy", {63'd0, busy_o}, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        run_div(1'b0, 32'd15, 32'd4, res, lat, bc);
        check("after rst 15/4", res, {32'd3, 32'd3});
        check("after rst latency", 64'(lat), 64'd33);
        drop_start("after rst");

        // Operand changes and start deassertion during ON are ignored.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i      = 1'b0;
        signed_div_i = 1'b1;
        opdata1_i    = 32'hDEADBEEF;
        opdata2_i    = 32'd0;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = k;
                res = result_o;
                break;
            end
        end
        check("ignore inputs result", res, {32'd2, 32'd14});
        check("ignore inputs latency", 64'(lat), 64'd33);
        @(negedge clk);
        check("ignore inputs drop ready", {63'd0, ready_o}, 64'd0);
        check("ignore inputs drop result", result_o, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
